niosii_pio_in: RTL



---
 rtl/niosii_pio_in.sv | 93 +++++++++
 1 files changed

// File: rtl/niosii_pio_in.sv
// Avalon-MM input port: synchronised level, per-bit edge capture with
// write-1-to-clear, and a maskable level interrupt.
module niosii_pio_in #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_LAST = CW'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] clr;
  logic [CW-1:0]         arm_cnt;
  logic                  armed;
  logic                  wr_en;
  logic [31:0]           rd_next;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_LAST);
  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev <= sync;
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = ~sync & prev;
      2:       edge_det = sync ^ prev;
      default: edge_det = sync & ~prev;
    endcase
  end

  // Edge detection stays off until the synchroniser and prev have flushed
  // the reset zeros, so inputs already active at reset are not captured.
  always_ff @(posedge clk) begin
    if (!reset_n)    arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + CW'(1);
  end

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edgecap <= '0;
      irqmask <= '0;
    end else begin
      edgecap <= (edgecap & ~clr) | (armed ? edge_det : '0);
      if (wr_en && address == 2'd2) irqmask <= writedata[DATA_WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[DATA_WIDTH-1:0] = sync;
      2'd2:    rd_next[DATA_WIDTH-1:0] = irqmask;
      2'd3:    rd_next[DATA_WIDTH-1:0] = edgecap;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule
